// File: rtl/fetch_instr_queue_pkg.sv
// Shared types for the fetch/decode instruction queue slice.
// cvw_t is the core configuration record; the queue only consumes XLEN.
package fetch_instr_queue_pkg;

    typedef struct packed {
        int unsigned XLEN;
    } cvw_t;

    localparam cvw_t DEFAULT_CVW      = '{XLEN: 32};
    localparam int   IQ_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/fetch_instr_queue_if.sv
// Enqueue (fetch side), dequeue (decode side) and flush signals of the queue.
// master = fetch/decode logic driving the queue, slave = the queue itself.
interface fetch_instr_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) ();
    logic                     FlushQ;
    logic                     EnqValidF;
    logic                     EnqReadyF;
    logic [XLEN-1:0]          EnqPCF;
    logic [31:0]              EnqInstrF;
    logic                     EnqCompressedF;
    logic                     DeqValidD;
    logic                     DeqReadyD;
    logic [XLEN-1:0]          DeqPCD;
    logic [31:0]              DeqInstrD;
    logic                     DeqCompressedD;
    logic [$clog2(DEPTH):0]   CountQ;

    modport master (
        output FlushQ, EnqValidF, EnqPCF, EnqInstrF, EnqCompressedF, DeqReadyD,
        input  EnqReadyF, DeqValidD, DeqPCD, DeqInstrD, DeqCompressedD, CountQ
    );

    modport slave (
        input  FlushQ, EnqValidF, EnqPCF, EnqInstrF, EnqCompressedF, DeqReadyD,
        output EnqReadyF, DeqValidD, DeqPCD, DeqInstrD, DeqCompressedD, CountQ
    );
endinterface

// File: rtl/fetch_instr_queue_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one combinational read port.
module fetch_instr_queue_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Storage write; cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/fetch_instr_queue.sv
// Decoupling FIFO between fetch spill/merge and Decode.
// Entry packing is {compressed, instr, pc}. Full/Empty come from the
// occupancy counter; there is no enqueue-through-full path so the decode
// stall never reaches the fetch ready.
module fetch_instr_queue
    import fetch_instr_queue_pkg::*;
#(
    parameter cvw_t P     = DEFAULT_CVW,
    parameter int   DEPTH = IQ_DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    fetch_instr_queue_if.slave iq
);
    localparam int XLEN   = P.XLEN;
    localparam int ENTRYW = XLEN + 33;
    localparam int PW     = $clog2(DEPTH);
    localparam int CW     = PW + 1;

    logic [PW-1:0]     rdPtr, wrPtr, rdPtrNext, wrPtrNext;
    logic [CW-1:0]     count, countNext;
    logic              full, empty, enqFire, deqFire;
    logic [ENTRYW-1:0] wrData, rdData;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign enqFire = iq.EnqValidF & ~full  & ~iq.FlushQ;
    assign deqFire = iq.DeqReadyD & ~empty & ~iq.FlushQ;
    assign wrData  = {iq.EnqCompressedF, iq.EnqInstrF, iq.EnqPCF};

    // Next pointer/count: flush wins, otherwise explicit enable muxes.
    always_comb begin
        rdPtrNext = rdPtr;
        wrPtrNext = wrPtr;
        countNext = count;
        if (iq.FlushQ) begin
            rdPtrNext = '0;
            wrPtrNext = '0;
            countNext = '0;
        end else begin
            if (enqFire) wrPtrNext = wrPtr + PW'(1);
            if (deqFire) rdPtrNext = rdPtr + PW'(1);
            if (enqFire & ~deqFire)      countNext = count + CW'(1);
            else if (deqFire & ~enqFire) countNext = count - CW'(1);
        end
    end

    // Pointer and occupancy flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            rdPtr <= rdPtrNext;
            wrPtr <= wrPtrNext;
            count <= countNext;
        end
    end

    fetch_instr_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRYW),
        .AW    (PW)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (enqFire),
        .wr_addr (wrPtr),
        .wr_data (wrData),
        .rd_addr (rdPtr),
        .rd_data (rdData)
    );

    assign iq.EnqReadyF      = ~full;
    assign iq.DeqValidD      = ~empty;
    assign iq.DeqPCD         = rdData[XLEN-1:0];
    assign iq.DeqInstrD      = rdData[XLEN+31:XLEN];
    assign iq.DeqCompressedD = rdData[ENTRYW-1];
    assign iq.CountQ         = count;
endmodule

// File: tb/tb_fetch_instr_queue.sv
// Directed bench for fetch_instr_queue: reset, single entry, fill/overflow,
// full with deq, streaming across wrap, flush, and async reset.
module tb_fetch_instr_queue;
    import fetch_instr_queue_pkg::*;

    logic clk;
    logic reset;
    int   assertCount = 0;
    int   failCount   = 0;

    fetch_instr_queue_if #(.XLEN(32), .DEPTH(4)) iqBus ();

    fetch_instr_queue #(.P(DEFAULT_CVW), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .iq    (iqBus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs and samples live 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setEnq(input logic v, input logic [31:0] pc, input logic [31:0] instr, input logic c);
        iqBus.EnqValidF      = v;
        iqBus.EnqPCF         = pc;
        iqBus.EnqInstrF      = instr;
        iqBus.EnqCompressedF = c;
    endtask

    logic [31:0] fillPC [4];
    logic        fillC  [4];

    initial begin
        fillPC[0] = 32'h100; fillPC[1] = 32'h102; fillPC[2] = 32'h106; fillPC[3] = 32'h108;
        fillC[0]  = 1'b1;    fillC[1]  = 1'b0;    fillC[2]  = 1'b1;    fillC[3]  = 1'b0;

        reset           = 1'b1;
        iqBus.FlushQ    = 1'b0;
        iqBus.DeqReadyD = 1'b0;
        setEnq(1'b0, 32'h0, 32'h0, 1'b0);
        step();
        step();
        reset = 1'b0;

        // 1: idle after reset, DeqReadyD ignored while empty
        iqBus.DeqReadyD = 1'b1;
        step();
        step();
        checkEq("rst_deqvalid", iqBus.DeqValidD, 1'b0);
        checkEq("rst_enqready", iqBus.EnqReadyF, 1'b1);
        checkEq("rst_count",    iqBus.CountQ, 3'd0);
        checkEq("rst_deqpc",    iqBus.DeqPCD, 32'h0);
        iqBus.DeqReadyD = 1'b0;

        // 2: single entry round trip
        setEnq(1'b1, 32'h8000_0000, 32'h0000_0013, 1'b0);
        step();
        setEnq(1'b0, 32'h0, 32'h0, 1'b0);
        checkEq("one_valid", iqBus.DeqValidD, 1'b1);
        checkEq("one_pc",    iqBus.DeqPCD, 32'h8000_0000);
        checkEq("one_instr", iqBus.DeqInstrD, 32'h0000_0013);
        checkEq("one_c",     iqBus.DeqCompressedD, 1'b0);
        checkEq("one_count", iqBus.CountQ, 3'd1);
        iqBus.DeqReadyD = 1'b1;
        step();
        iqBus.DeqReadyD = 1'b0;
        checkEq("one_drained", iqBus.CountQ, 3'd0);
        checkEq("one_empty",   iqBus.DeqValidD, 1'b0);

        // 3: fill to full while decode stalls; overflow enq ignored
        for (int i = 0; i < 4; i++) begin
            setEnq(1'b1, fillPC[i], 32'h1000 + 32'(i), fillC[i]);
            step();
        end
        checkEq("full_count", iqBus.CountQ, 3'd4);
        checkEq("full_ready", iqBus.EnqReadyF, 1'b0);
        setEnq(1'b1, 32'h200, 32'hDEAD, 1'b1);
        step();
        checkEq("ovf_count", iqBus.CountQ, 3'd4);
        checkEq("ovf_head_pc", iqBus.DeqPCD, 32'h100);
        checkEq("ovf_head_c",  iqBus.DeqCompressedD, 1'b1);

        // 4: full with both sides active: only deq fires
        iqBus.DeqReadyD = 1'b1;
        step();
        setEnq(1'b0, 32'h0, 32'h0, 1'b0);
        iqBus.DeqReadyD = 1'b0;
        checkEq("fulldeq_count", iqBus.CountQ, 3'd3);
        checkEq("fulldeq_ready", iqBus.EnqReadyF, 1'b1);

        // drain the rest in order
        iqBus.DeqReadyD = 1'b1;
        for (int i = 1; i < 4; i++) begin
            checkEq($sformatf("drain%0d_pc", i),    iqBus.DeqPCD, fillPC[i]);
            checkEq($sformatf("drain%0d_c", i),     iqBus.DeqCompressedD, fillC[i]);
            checkEq($sformatf("drain%0d_instr", i), iqBus.DeqInstrD, 32'h1000 + 32'(i));
            step();
        end
        iqBus.DeqReadyD = 1'b0;
        checkEq("drain_empty", iqBus.CountQ, 3'd0);

        // 5: stream at Count=2 across the pointer wrap
        setEnq(1'b1, 32'h300, 32'h3000, 1'b0);
        step();
        setEnq(1'b1, 32'h304, 32'h3001, 1'b1);
        step();
        checkEq("stream_start", iqBus.CountQ, 3'd2);
        iqBus.DeqReadyD = 1'b1;
        for (int k = 0; k < 10; k++) begin
            setEnq(1'b1, 32'h308 + 32'(4 * k), 32'h3002 + 32'(k), k[0]);
            checkEq($sformatf("stream%0d_pc", k), iqBus.DeqPCD, 32'h300 + 32'(4 * k));
            checkEq($sformatf("stream%0d_c", k),  iqBus.DeqCompressedD, (k % 2) == 1);
            step();
            checkEq($sformatf("stream%0d_count", k), iqBus.CountQ, 3'd2);
        end
        iqBus.DeqReadyD = 1'b0;
        setEnq(1'b0, 32'h0, 32'h0, 1'b0);
        checkEq("stream_head", iqBus.DeqPCD, 32'h328);

        // 6: flush at Count=3 discards the concurrent enq and deq
        setEnq(1'b1, 32'h400, 32'h4000, 1'b0);
        step();
        checkEq("preflush_count", iqBus.CountQ, 3'd3);
        setEnq(1'b1, 32'h500, 32'h5000, 1'b0);
        iqBus.DeqReadyD = 1'b1;
        iqBus.FlushQ    = 1'b1;
        step();
        iqBus.FlushQ    = 1'b0;
        iqBus.DeqReadyD = 1'b0;
        setEnq(1'b0, 32'h0, 32'h0, 1'b0);
        checkEq("flush_count", iqBus.CountQ, 3'd0);
        checkEq("flush_valid", iqBus.DeqValidD, 1'b0);
        checkEq("flush_ready", iqBus.EnqReadyF, 1'b1);
        setEnq(1'b1, 32'h600, 32'h0000_ABCD, 1'b1);
        step();
        setEnq(1'b0, 32'h0, 32'h0, 1'b0);
        checkEq("postflush_valid", iqBus.DeqValidD, 1'b1);
        checkEq("postflush_pc",    iqBus.DeqPCD, 32'h600);
        checkEq("postflush_instr", iqBus.DeqInstrD, 32'h0000_ABCD);
        checkEq("postflush_c",     iqBus.DeqCompressedD, 1'b1);
        checkEq("postflush_count", iqBus.CountQ, 3'd1);

        // async reset in the middle of a burst
        setEnq(1'b1, 32'h700, 32'h7000, 1'b0);
        step();
        checkEq("burst_count", iqBus.CountQ, 3'd2);
        #2;
        reset = 1'b1;
        #1;
        checkEq("arst_count", iqBus.CountQ, 3'd0);
        checkEq("arst_valid", iqBus.DeqValidD, 1'b0);
        checkEq("arst_ready", iqBus.EnqReadyF, 1'b1);
        checkEq("arst_pc",    iqBus.DeqPCD, 32'h0);
        checkEq("arst_instr", iqBus.DeqInstrD, 32'h0);
        setEnq(1'b0, 32'h0, 32'h0, 1'b0);
        step();
        reset = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
